sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the board's asynchronous 8-bit external SRAM (21-bit address). It sits between the machine core and the SRAM pins in the top-level and runs on `sysclk` (28 MHz). Each requester gets a level request/pulse acknowledge handshake. The block turns every granted request into a correctly timed read or write cycle (address setup, write-enable pulse, data hold), so the two requesters never drive the SRAM at the same time. The bidirectional data pin stays in the top-level, which builds it from `sram_dq_o`, `sram_dq_oe` and `sram_dq_i`.

---
 rtl/sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the asynchronous 8-bit external SRAM.
// Each granted request becomes a timed read or write cycle (setup, WE pulse, hold) ending in an ack pulse.
module sram_arbiter #(
    parameter int ADDR_W        = 21,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p0_wdata,
    input  logic [7:0]        p1_wdata,
    output logic              p0_ack,
    output logic              p1_ack,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              we_n_q, we_n_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              pick;

    // Port 1 wins when it is the only requester, or on a tie when port 0 had the last grant.
    assign pick = p1_req & (~p0_req | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        dq_o_d       = dq_o_q;
        dq_oe_d      = dq_oe_q;
        we_n_d       = we_n_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (p0_req | p1_req) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    we_d         = pick ? p1_we : p0_we;
                    addr_d       = pick ? p1_addr : p0_addr;
                    if (pick ? p1_we : p0_we) begin
                        state_d = ST_SETUP;
                        dq_o_d  = pick ? p1_wdata : p0_wdata;
                        dq_oe_d = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                we_n_d  = 1'b0;
                cnt_d   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (we_q) begin
                        we_n_d  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        rdata_d = sram_dq_i;
                        state_d = ST_DONE;
                        ack0_d  = ~gnt_q;
                        ack1_d  = gnt_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                // Data stays driven through HOLD so it outlives the WE rise by a cycle.
                dq_oe_d = 1'b0;
                state_d = ST_DONE;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            dq_o_q       <= 8'h00;
            dq_oe_q      <= 1'b0;
            we_n_q       <= 1'b1;
            rdata_q      <= 8'h00;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            dq_o_q       <= dq_o_d;
            dq_oe_q      <= dq_oe_d;
            we_n_q       <= we_n_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    assign p0_ack     = ack0_q;
    assign p1_ack     = ack1_q;
    assign rdata      = rdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random two-port traffic checked each cycle
// against a transaction-level timing model; a second instance covers ACCESS_CYCLES=5.
module tb_sram_arbiter;
    localparam int N  = 2;
    localparam int AW = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          p_req [2];
    logic          p_we  [2];
    logic [AW-1:0] p_addr[2];
    logic [7:0]    p_wd  [2];
    logic          ack0, ack1, busy, wen, oe;
    logic [7:0]    rdata, dqo, dqi;
    logic [AW-1:0] saddr;
    logic [7:0]    mem    [16];
    logic [7:0]    ref_mem[16];

    assign dqi = mem[saddr[3:0]];

    sram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(N)) u_dut (
        .sysclk(clk), .reset(rst),
        .p0_req(p_req[0]), .p1_req(p_req[1]), .p0_we(p_we[0]), .p1_we(p_we[1]),
        .p0_addr(p_addr[0]), .p1_addr(p_addr[1]), .p0_wdata(p_wd[0]), .p1_wdata(p_wd[1]),
        .p0_ack(ack0), .p1_ack(ack1), .rdata(rdata), .busy(busy), .sram_addr(saddr),
        .sram_dq_o(dqo), .sram_dq_oe(oe), .sram_dq_i(dqi), .sram_we_n(wen)
    );

    logic          r5, w5, k0_5, k1_5, busy5, wen5, oe5;
    logic [AW-1:0] a5, addr5;
    logic [7:0]    d5, rd5, do5;

    sram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(5)) u_dut5 (
        .sysclk(clk), .reset(rst),
        .p0_req(r5), .p1_req(1'b0), .p0_we(w5), .p1_we(1'b0),
        .p0_addr(a5), .p1_addr('0), .p0_wdata(d5), .p1_wdata(8'h00),
        .p0_ack(k0_5), .p1_ack(k1_5), .rdata(rd5), .busy(busy5), .sram_addr(addr5),
        .sram_dq_o(do5), .sram_dq_oe(oe5), .sram_dq_i(8'h77), .sram_we_n(wen5)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Transaction-level reference: current grant edge, port, direction, and when IDLE may grant again.
    int            e = 0, nfree = 0, cg = -1000, cp = 0, lg = 1;
    logic          cwe = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [7:0]    exp_dqo = 8'h00, exp_rd = 8'h00, cval = 8'h00;
    int            obs_ack_e[2];
    int            n_wlow = 0;
    int            keep_mode = 0;
    int            ackq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic newreq(input int p);
        p_req[p]  = 1'b1;
        p_we[p]   = 1'($urandom % 2);
        p_addr[p] = AW'($urandom);
        p_wd[p]   = 8'($urandom);
    endtask

    task automatic tick();
        logic          g_ok, rnow, gwe, ea0, ea1;
        int            gp, ackt;
        logic [AW-1:0] gaddr;
        logic [7:0]    gwd;
        g_ok = 1'b0; gp = 0; gwe = 1'b0; gaddr = '0; gwd = 8'h00; rnow = rst;
        if (!rnow && e + 1 >= nfree && (p_req[0] || p_req[1])) begin
            gp    = (p_req[0] && p_req[1]) ? ((lg == 1) ? 0 : 1) : (p_req[1] ? 1 : 0);
            g_ok  = 1'b1;
            gwe   = p_we[gp];
            gaddr = p_addr[gp];
            gwd   = p_wd[gp];
        end
        if (wen === 1'b0 && oe === 1'b1) mem[saddr[3:0]] = dqo;
        @(posedge clk);
        e++;
        if (rnow) begin
            cg = -1000; cwe = 1'b0; nfree = e + 1; lg = 1;
            exp_addr = '0; exp_dqo = 8'h00; exp_rd = 8'h00;
        end else if (g_ok) begin
            cg = e; cp = gp; cwe = gwe; lg = gp; exp_addr = gaddr;
            if (gwe) begin
                exp_dqo = gwd;
                ref_mem[gaddr[3:0]] = gwd;
                nfree = e + N + 4;
            end else begin
                cval = ref_mem[gaddr[3:0]];
                nfree = e + N + 2;
            end
        end
        if (!cwe && e == cg + N) exp_rd = cval;
        @(negedge clk);
        ackt = cg + (cwe ? N + 2 : N);
        ea0 = (e == ackt) && (cp == 0);
        ea1 = (e == ackt) && (cp == 1);
        chk("ack0", 32'(ack0), 32'(ea0));
        chk("ack1", 32'(ack1), 32'(ea1));
        chk("busy", 32'(busy), 32'(e >= cg && e < nfree - 1));
        chk("we_n", 32'(wen), 32'(!(cwe && e >= cg + 1 && e <= cg + N)));
        chk("dq_oe", 32'(oe), 32'(cwe && e >= cg && e <= cg + N + 1));
        chk("sram_addr", 32'(saddr), 32'(exp_addr));
        chk("dq_o", 32'(dqo), 32'(exp_dqo));
        chk("rdata", 32'(rdata), 32'(exp_rd));
        if (ack0 === 1'b1) begin obs_ack_e[0] = e; ackq.push_back(0); end
        if (ack1 === 1'b1) begin obs_ack_e[1] = e; ackq.push_back(1); end
        if (wen === 1'b0) n_wlow++;
        for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? ea0 : ea1) begin
                if (keep_mode == 2 && $urandom % 3 == 0) newreq(p);
                else if (keep_mode != 1) p_req[p] = 1'b0;
            end else if (keep_mode == 2 && !p_req[p] && $urandom % 4 == 0) begin
                newreq(p);
            end
        end
    endtask

    task automatic run5(input logic we, output int ack_at, output int nlow);
        r5 = 1'b1; w5 = we; a5 = 21'h0ABC5; d5 = 8'h3C;
        ack_at = -1; nlow = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (k0_5 === 1'b1) begin ack_at = j; r5 = 1'b0; end
            if (wen5 === 1'b0) nlow++;
        end
    endtask

    initial begin
        int at5, low5;
        for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        obs_ack_e[0] = -1; obs_ack_e[1] = -1;
        r5 = 1'b0; w5 = 1'b0; a5 = '0; d5 = 8'h00;
        for (int p = 0; p < 2; p++) newreq(p);

        // Reset with random requests present.
        rst = 1'b1;
        tick();
        tick();
        chk("rst_we_n", 32'(wen), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        tick();

        // Single read by port 0.
        mem[4'hD] = 8'h5A; ref_mem[4'hD] = 8'h5A;
        p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 21'h1ABCD;
        repeat (6) tick();
        chk("rd_ack_lat", 32'(obs_ack_e[0] - cg), 32'(N));
        chk("rd_data", 32'(rdata), 32'h5A);
        chk("rd_addr", 32'(saddr), 32'h1ABCD);
        chk("rd_no_p1_ack", 32'(obs_ack_e[1]), 32'(-1));

        // Single write by port 1.
        n_wlow = 0;
        p_req[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 21'h00010; p_wd[1] = 8'hC3;
        repeat (8) tick();
        chk("wr_ack_lat", 32'(obs_ack_e[1] - cg), 32'(N + 2));
        chk("wr_we_low", 32'(n_wlow), 32'(N));
        chk("wr_mem", 32'(mem[4'h0]), 32'hC3);

        // Contention: both ports hold reads for six grants.
        ackq.delete();
        keep_mode = 1;
        p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 21'h00005;
        p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 21'h00010;
        repeat (6 * (N + 2)) tick();
        keep_mode = 0;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        repeat (4) tick();
        chk("cont_acks", 32'(ackq.size()), 32'(6));
        for (int i = 0; i < 6 && i < ackq.size(); i++) chk("cont_order", 32'(ackq[i]), 32'(i % 2));

        // Reset while the write strobe is low.
        p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 21'h00003; p_wd[0] = 8'h99;
        tick();
        tick();
        chk("rstw_pre_we_n", 32'(wen), 32'(0));
        rst = 1'b1;
        obs_ack_e[0] = -1;
        tick();
        chk("rstw_we_n", 32'(wen), 32'(1));
        chk("rstw_oe", 32'(oe), 32'(0));
        chk("rstw_no_ack", 32'(obs_ack_e[0]), 32'(-1));
        rst = 1'b0;
        repeat (8) tick();
        chk("rstw_redo_lat", 32'(obs_ack_e[0] - cg), 32'(N + 2));
        chk("rstw_mem", 32'(mem[4'h3]), 32'h99);

        // Random traffic, including requests dropped mid-access at the end.
        keep_mode = 2;
        repeat (400) tick();
        keep_mode = 0;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        repeat (10) tick();

        // ACCESS_CYCLES = 5 instance.
        run5(1'b0, at5, low5);
        chk("n5_rd_ack", 32'(at5), 32'(5));
        chk("n5_rd_data", 32'(rd5), 32'h77);
        chk("n5_rd_addr", 32'(addr5), 32'h0ABC5);
        run5(1'b1, at5, low5);
        chk("n5_wr_ack", 32'(at5), 32'(7));
        chk("n5_wr_we_low", 32'(low5), 32'(5));
        chk("n5_wr_dq", 32'(do5), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
